edge_event_arbiter: RTL and testbench

- Multi-channel edge-event controller: watches N_CH single-bit input signals, detects rising and falling edges on each, and queues them as pending events.
- Shares one event output port between all channels with round-robin arbitration and a valid/ready handshake.
- Sits between raw control/status lines and a single event consumer (interrupt logic, logger). Per-channel enables and sticky overflow flags make it configurable and observable.

---
 rtl/edge_evt_pkg.sv | 12 +
 rtl/edge_det.sv | 63 ++++++
 rtl/edge_event_arbiter.sv | 107 ++++++++++
 tb/tb_edge_event_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared constants and helpers for the edge-event arbiter.
package edge_evt_pkg;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

  // Round-robin increment with wrap at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Per-channel edge detector with rise/fall pending bits, age order and sticky overflow.
module edge_det
  import edge_evt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  input  logic grant_rise,
  input  logic grant_fall,
  input  logic ovf_clr,
  output logic rise_pend,
  output logic fall_pend,
  output logic order,
  output logic ovf,
  output logic pend_nxt_c
);

  logic prev_q;
  logic rise_det;
  logic fall_det;
  logic r_keep;
  logic f_keep;
  logic rise_nxt;
  logic fall_nxt;
  logic order_nxt;
  logic ovf_nxt;

  // order holds the type of the older pending event; a same-cycle grant plus new edge counts as fresh.
  always_comb begin
    rise_det   = en & sig & ~prev_q;
    fall_det   = en & ~sig & prev_q;
    r_keep     = rise_pend & ~grant_rise;
    f_keep     = fall_pend & ~grant_fall;
    rise_nxt   = r_keep | rise_det;
    fall_nxt   = f_keep | fall_det;
    order_nxt  = order;
    if (rise_det && !r_keep) begin
      order_nxt = f_keep ? EVT_FALL : EVT_RISE;
    end else if (fall_det && !f_keep) begin
      order_nxt = r_keep ? EVT_RISE : EVT_FALL;
    end
    ovf_nxt    = (ovf & ~ovf_clr) | (rise_det & r_keep) | (fall_det & f_keep);
    pend_nxt_c = rise_nxt | fall_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b0;
      rise_pend <= 1'b0;
      fall_pend <= 1'b0;
      order     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      prev_q    <= sig;
      rise_pend <= rise_nxt;
      fall_pend <= fall_nxt;
      order     <= order_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event queue sharing one valid/ready event port via round-robin.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig,
  input  logic [N_CH-1:0] en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            busy
);

  logic [N_CH-1:0] rise_pend;
  logic [N_CH-1:0] fall_pend;
  logic [N_CH-1:0] order;
  logic [N_CH-1:0] pend_nxt;
  logic [N_CH-1:0] pend_any;
  logic [N_CH-1:0] grant_rise;
  logic [N_CH-1:0] grant_fall;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] ptr_nxt;
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] gidx;
  logic [CH_W-1:0] ch_nxt;
  logic            slot_free;
  logic            found;
  logic            sel_rise;
  logic            valid_nxt;
  logic            rise_nxt;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_det
    edge_det u_det (
      .clk        (clk),
      .rst        (rst),
      .sig        (sig[i]),
      .en         (en[i]),
      .grant_rise (grant_rise[i]),
      .grant_fall (grant_fall[i]),
      .ovf_clr    (ovf_clr[i]),
      .rise_pend  (rise_pend[i]),
      .fall_pend  (fall_pend[i]),
      .order      (order[i]),
      .ovf        (ovf[i]),
      .pend_nxt_c (pend_nxt[i])
    );
  end

  // Round-robin scan from ptr; the grant only fires when the output slot is free.
  always_comb begin
    pend_any   = rise_pend | fall_pend;
    slot_free  = ~evt_valid | evt_ready;
    found      = 1'b0;
    gidx       = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = CH_W'((32'(ptr) + k) % N_CH);
      if (!found && pend_any[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    sel_rise   = rise_pend[gidx] & (~fall_pend[gidx] | (order[gidx] == EVT_RISE));
    grant_rise = '0;
    grant_fall = '0;
    valid_nxt  = evt_valid;
    ch_nxt     = evt_ch;
    rise_nxt   = evt_rise;
    ptr_nxt    = ptr;
    if (slot_free) begin
      if (found) begin
        if (sel_rise) grant_rise[gidx] = 1'b1;
        else          grant_fall[gidx] = 1'b1;
        valid_nxt = 1'b1;
        ch_nxt    = gidx;
        rise_nxt  = sel_rise ? EVT_RISE : EVT_FALL;
        ptr_nxt   = CH_W'(rr_next(32'(gidx), N_CH));
      end else begin
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      ptr       <= '0;
      busy      <= 1'b0;
    end else begin
      evt_valid <= valid_nxt;
      evt_ch    <= ch_nxt;
      evt_rise  <= rise_nxt;
      ptr       <= ptr_nxt;
      busy      <= (|pend_nxt) | valid_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N_CH=4).
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic [3:0] en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  edge_event_arbiter #(.N_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .en        (en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] ch, input logic r);
    chk({tag, "_valid"}, 16'(evt_valid), 16'(1'b1));
    chk({tag, "_ch"},    16'(evt_ch),    16'(ch));
    chk({tag, "_rise"},  16'(evt_rise),  16'(r));
  endtask

  initial begin
    rst = 1'b1; sig = 4'b0000; en = 4'hF; evt_ready = 1'b1; ovf_clr = 4'b0000;
    tick(); tick();
    chk("rst_valid", 16'(evt_valid), 16'(1'b0));
    chk("rst_busy",  16'(busy),      16'(1'b0));
    chk("rst_ovf",   16'(ovf),       16'(4'b0000));
    chk("rst_ch",    16'(evt_ch),    16'(2'd0));
    chk("rst_rise",  16'(evt_rise),  16'(1'b0));
    rst = 1'b0;
    tick();
    chk("idle_valid", 16'(evt_valid), 16'(1'b0));

    // single rise on ch2
    sig = 4'b0100;
    tick();
    chk("t1_det_valid", 16'(evt_valid), 16'(1'b0));
    chk("t1_det_busy",  16'(busy),      16'(1'b1));
    tick();
    chk_evt("t1_evt", 2'd2, 1'b1);
    chk("t1_evt_busy", 16'(busy), 16'(1'b1));
    tick();
    chk("t1_done_valid", 16'(evt_valid), 16'(1'b0));
    chk("t1_done_busy",  16'(busy),      16'(1'b0));

    // round-robin from pointer 0
    rst = 1'b1; sig = 4'b0000;
    tick();
    rst = 1'b0;
    sig = 4'b1011;
    tick();
    chk("t2_det_valid", 16'(evt_valid), 16'(1'b0));
    tick(); chk_evt("t2_e0", 2'd0, 1'b1);
    tick(); chk_evt("t2_e1", 2'd1, 1'b1);
    tick(); chk_evt("t2_e3", 2'd3, 1'b1);
    tick();
    chk("t2_done_valid", 16'(evt_valid), 16'(1'b0));
    chk("t2_done_busy",  16'(busy),      16'(1'b0));

    // backpressure on three falls
    evt_ready = 1'b0; sig = 4'b0000;
    tick();
    chk("t3_det_busy", 16'(busy), 16'(1'b1));
    tick();
    chk_evt("t3_held0", 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_evt("t3_hold", 2'd0, 1'b0);
    end
    evt_ready = 1'b1;
    tick(); chk_evt("t3_e1", 2'd1, 1'b0);
    tick(); chk_evt("t3_e3", 2'd3, 1'b0);
    tick();
    chk("t3_done_valid", 16'(evt_valid), 16'(1'b0));

    // ordering and overflow on ch1 with the slot blocked by ch0
    evt_ready = 1'b0; sig = 4'b0001;
    tick(); tick();
    chk_evt("t4_blk", 2'd0, 1'b1);
    sig = 4'b0011; tick();
    sig = 4'b0001; tick();
    chk("t4_no_ovf", 16'(ovf), 16'(4'b0000));
    sig = 4'b0011; tick();
    chk("t4_ovf", 16'(ovf), 16'(4'b0010));
    chk_evt("t4_still", 2'd0, 1'b1);
    ovf_clr = 4'b0010; tick(); ovf_clr = 4'b0000;
    chk("t4_ovf_clr", 16'(ovf), 16'(4'b0000));
    evt_ready = 1'b1;
    tick(); chk_evt("t4_rise_first", 2'd1, 1'b1);
    tick(); chk_evt("t4_fall_next",  2'd1, 1'b0);
    tick();
    chk("t4_done_valid", 16'(evt_valid), 16'(1'b0));
    chk("t4_done_busy",  16'(busy),      16'(1'b0));

    // disabled channel toggling
    en = 4'b1110;
    sig = 4'b0010; tick(); chk("t5_v_a", 16'(evt_valid), 16'(1'b0));
    sig = 4'b0011; tick(); chk("t5_v_b", 16'(evt_valid), 16'(1'b0));
    sig = 4'b0010; tick(); chk("t5_v_c", 16'(evt_valid), 16'(1'b0));
    tick();
    chk("t5_busy", 16'(busy), 16'(1'b0));
    chk("t5_ovf",  16'(ovf),  16'(4'b0000));
    en = 4'hF;

    // reset mid-handshake with pending events and an overflow
    evt_ready = 1'b0; sig = 4'b1101;
    tick(); tick();
    chk_evt("t6_held", 2'd2, 1'b1);
    sig = 4'b0101; tick();
    sig = 4'b1101; tick();
    chk("t6_ovf", 16'(ovf), 16'(4'b1000));
    rst = 1'b1; sig = 4'b0000;
    tick();
    chk("t6_rst_valid", 16'(evt_valid), 16'(1'b0));
    chk("t6_rst_busy",  16'(busy),      16'(1'b0));
    chk("t6_rst_ovf",   16'(ovf),       16'(4'b0000));
    rst = 1'b0; evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_after_valid", 16'(evt_valid), 16'(1'b0));
      chk("t6_after_busy",  16'(busy),      16'(1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
